// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and helpers for the iterative RV32M multiply/divide unit.
package muldiv_pkg;
    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } md_op_e;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} md_state_e;

    function automatic logic is_div(md_op_e op);
        return op[2];
    endfunction

    function automatic logic is_rem(md_op_e op);
        return op[2] & op[1];
    endfunction
endpackage

// File: rtl/md_sign_fix.sv
// md_sign_fix: conditional two's-complement negate, used both for operand
// magnitudes and for restoring the sign of the final product/quotient.
module md_sign_fix #(
    parameter int width = 32
) (
    input  logic [width-1:0] val,
    input  logic             neg,
    output logic [width-1:0] res
);
    assign res = neg ? -val : val;
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide, 1 bit per cycle on magnitudes,
// with divide-by-zero and signed overflow resolved at accept.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int w     = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [w-1:0]     a,
    input  logic [w-1:0]     b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [w-1:0]     result,
    output logic [TAG_W-1:0] out_tag
);
    localparam int CW = $clog2(w) + 1;

    md_state_e      state, state_n;
    md_op_e         op_in, op_q;
    logic [2*w-1:0] acc, fix_in, fixed;
    logic [w-1:0]   opb, abs_a, abs_b, spec_res, fix_res, diff;
    logic [w:0]     mul_sum;
    logic [CW-1:0]  cnt;
    logic           neg_q, sa, sb, accept, div_zero, ovf, special, last, ge;

    assign op_in     = md_op_e'(op);
    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign accept    = in_valid & in_ready & ~flush;
    assign last      = cnt == CW'(w - 1);

    assign sa = a[w-1] & (op_in inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
    assign sb = b[w-1] & (op_in inside {OP_MUL, OP_MULH, OP_DIV, OP_REM});

    md_sign_fix #(.width(w)) u_abs_a (.val(a), .neg(sa), .res(abs_a));
    md_sign_fix #(.width(w)) u_abs_b (.val(b), .neg(sb), .res(abs_b));

    assign div_zero = is_div(op_in) & (b == '0);
    assign ovf      = (op_in == OP_DIV || op_in == OP_REM) & (a == {1'b1, {(w-1){1'b0}}}) & (&b);
    assign special  = div_zero | ovf;
    assign spec_res = div_zero ? (is_rem(op_in) ? a : '1) : (is_rem(op_in) ? '0 : a);

    // Multiply: add multiplicand into the upper half when the low bit is set, then shift right.
    assign mul_sum = {1'b0, acc[2*w-1:w]} + (acc[0] ? {1'b0, opb} : '0);
    // Divide: the partial remainder is w+1 bits after the shift, but the difference always fits w.
    assign ge   = acc[2*w-1:w-1] >= {1'b0, opb};
    assign diff = acc[2*w-2:w-1] - opb;

    assign fix_in  = is_div(op_q) ? {{w{1'b0}}, is_rem(op_q) ? acc[2*w-1:w] : acc[w-1:0]} : acc;
    md_sign_fix #(.width(2*w)) u_fix (.val(fix_in), .neg(neg_q), .res(fixed));
    assign fix_res = (op_q == OP_MUL || is_div(op_q)) ? fixed[w-1:0] : fixed[2*w-1:w];

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_n;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = special ? DONE : CALC;
            CALC:    if (last) state_n = FIX;
            FIX:     state_n = DONE;
            DONE:    if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (flush) state_n = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            acc     <= '0;
            opb     <= '0;
            neg_q   <= 1'b0;
            op_q    <= OP_MUL;
            out_tag <= '0;
            result  <= '0;
            cnt     <= '0;
        end else begin
            cnt <= (state == CALC && !flush && !last) ? cnt + 1'b1 : '0;
            if (accept) begin
                op_q    <= op_in;
                out_tag <= in_tag;
                neg_q   <= is_rem(op_in) ? sa : sa ^ sb;
                opb     <= is_div(op_in) ? abs_b : abs_a;
                acc     <= {{w{1'b0}}, is_div(op_in) ? abs_a : abs_b};
                if (special) result <= spec_res;
            end else if (state == CALC && !flush)
                acc <= !is_div(op_q) ? {mul_sum, acc[w-1:1]}
                     : ge ? {diff, acc[w-2:0], 1'b1} : {acc[2*w-2:0], 1'b0};
            else if (state == FIX && !flush)
                result <= fix_res;
        end
endmodule
